// File: rtl/alu4_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu4_nibble_seq
// Description : Drives a combinational WIDTH-bit ALU slice once per clock to
//               build a WIDTH*NIBBLES-bit result with word-level flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_nibble_seq #(
  parameter int WIDTH    = 4,
  parameter int NIBBLES  = 4,
  parameter int OP_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH*NIBBLES-1:0]   opa,
  input  logic [WIDTH*NIBBLES-1:0]   opb,
  input  logic                       cin,
  input  logic                       b_zero_in,
  input  logic                       b_inv_in,
  input  logic [OP_WIDTH-1:0]        op_in,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic                       alu_y,
  output logic                       alu_b_zero,
  output logic                       alu_b_inv,
  output logic [OP_WIDTH-1:0]        alu_op,
  input  logic [WIDTH-1:0]           alu_s,
  input  logic                       alu_c,
  input  logic                       alu_zero,
  input  logic                       alu_overflow,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH*NIBBLES-1:0]   result,
  output logic                       carry_out,
  output logic                       zero_out,
  output logic                       overflow_out
);

  localparam int WORD_W = WIDTH * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NIBBLES - 1);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_RUN  = 1'b1;

  logic [0:0]          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_a;
  logic [WORD_W-1:0]   r_b;
  logic [WORD_W-1:0]   r_result;
  logic                r_carry;
  logic                r_zacc;
  logic                r_b_zero;
  logic                r_b_inv;
  logic [OP_WIDTH-1:0] r_op;
  logic                r_done;
  logic                r_carry_out;
  logic                r_zero_out;
  logic                r_overflow_out;

  assign alu_a        = r_a[r_idx*WIDTH +: WIDTH];
  assign alu_b        = r_b[r_idx*WIDTH +: WIDTH];
  assign alu_y        = r_carry;
  assign alu_b_zero   = r_b_zero;
  assign alu_b_inv    = r_b_inv;
  assign alu_op       = r_op;

  assign busy         = (r_state == C_RUN);
  assign done         = r_done;
  assign result       = r_result;
  assign carry_out    = r_carry_out;
  assign zero_out     = r_zero_out;
  assign overflow_out = r_overflow_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= C_IDLE;
      r_idx          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_carry        <= 1'b0;
      r_zacc         <= 1'b0;
      r_b_zero       <= 1'b0;
      r_b_inv        <= 1'b0;
      r_op           <= '0;
      r_done         <= 1'b0;
      r_carry_out    <= 1'b0;
      r_zero_out     <= 1'b0;
      r_overflow_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_a      <= opa;
            r_b      <= opb;
            r_b_zero <= b_zero_in;
            r_b_inv  <= b_inv_in;
            r_op     <= op_in;
            r_carry  <= cin;
            r_zacc   <= 1'b1;
            r_idx    <= '0;
            r_state  <= C_RUN;
          end
        end
        C_RUN: begin
          // Upper nibbles keep stale data until their own step overwrites them.
          r_result[r_idx*WIDTH +: WIDTH] <= alu_s;
          r_carry <= alu_c;
          r_zacc  <= r_zacc & alu_zero;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == C_LAST) begin
            r_carry_out    <= alu_c;
            r_overflow_out <= alu_overflow;
            r_zero_out     <= r_zacc & alu_zero;
            r_state        <= C_IDLE;
            r_done         <= 1'b1;
            r_idx          <= '0;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu4_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_nibble_seq
// Description : Bench for alu4_nibble_seq with a behavioural 4-bit slice and
//               a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu4_nibble_seq;
  localparam int WIDTH    = 4;
  localparam int NIBBLES  = 4;
  localparam int OP_WIDTH = 2;
  localparam int WW       = WIDTH * NIBBLES;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [WW-1:0]       opa = '0, opb = '0;
  logic                cin = 1'b0, b_zero_in = 1'b0, b_inv_in = 1'b0;
  logic [OP_WIDTH-1:0] op_in = '0;
  logic [WIDTH-1:0]    alu_a, alu_b, alu_s;
  logic                alu_y, alu_b_zero, alu_b_inv, alu_c, alu_zero, alu_overflow;
  logic [OP_WIDTH-1:0] alu_op;
  logic                busy, done, carry_out, zero_out, overflow_out;
  logic [WW-1:0]       result;

  int checks = 0;
  int failures = 0;

  alu4_nibble_seq #(.WIDTH(WIDTH), .NIBBLES(NIBBLES), .OP_WIDTH(OP_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb), .cin(cin),
    .b_zero_in(b_zero_in), .b_inv_in(b_inv_in), .op_in(op_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_b_zero(alu_b_zero),
    .alu_b_inv(alu_b_inv), .alu_op(alu_op), .alu_s(alu_s), .alu_c(alu_c),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .zero_out(zero_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  // Slice: op 0 add, 1 and, 2 or, 3 xor; B may be zeroed then inverted.
  logic [WIDTH-1:0] sl_bn;
  logic [WIDTH:0]   sl_t;
  always_comb begin
    sl_bn        = alu_b_zero ? '0 : alu_b;
    if (alu_b_inv) sl_bn = ~sl_bn;
    sl_t         = '0;
    alu_s        = '0;
    alu_c        = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      2'd0: begin
        sl_t         = {1'b0, alu_a} + {1'b0, sl_bn} + {{WIDTH{1'b0}}, alu_y};
        alu_s        = sl_t[WIDTH-1:0];
        alu_c        = sl_t[WIDTH];
        alu_overflow = (alu_a[WIDTH-1] == sl_bn[WIDTH-1]) && (alu_s[WIDTH-1] != alu_a[WIDTH-1]);
      end
      2'd1:    alu_s = alu_a & sl_bn;
      2'd2:    alu_s = alu_a | sl_bn;
      default: alu_s = alu_a ^ sl_bn;
    endcase
    alu_zero = (alu_s == '0);
  end

  typedef struct {
    logic [WW-1:0]       a;
    logic [WW-1:0]       b;
    logic                ci;
    logic                bz;
    logic                bi;
    logic [OP_WIDTH-1:0] op;
    logic [WW-1:0]       res;
    logic                c;
    logic                z;
    logic                v;
  } vec_t;

  // Word-level reference computed directly from the operation definition.
  function automatic vec_t model(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                 input logic ci, input logic bz, input logic bi,
                                 input logic [OP_WIDTH-1:0] op);
    vec_t r;
    logic [WW-1:0] be;
    logic [WW:0]   sum;
    r.a = a; r.b = b; r.ci = ci; r.bz = bz; r.bi = bi; r.op = op;
    be = bz ? '0 : b;
    if (bi) be = ~be;
    r.c = 1'b0; r.v = 1'b0;
    case (op)
      2'd0: begin
        sum   = {1'b0, a} + {1'b0, be} + {{WW{1'b0}}, ci};
        r.res = sum[WW-1:0];
        r.c   = sum[WW];
        r.v   = (a[WW-1] == be[WW-1]) && (r.res[WW-1] != a[WW-1]);
      end
      2'd1:    r.res = a & be;
      2'd2:    r.res = a | be;
      default: r.res = a ^ be;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives start there and returns at the done cycle.
  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    opa = v.a; opb = v.b; cin = v.ci; b_zero_in = v.bz; b_inv_in = v.bi; op_in = v.op;
    start = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin cyc = i; break; end
    end
    chk({tag, " latency"}, cyc, NIBBLES + 1);
    chk({tag, " result"},  {16'h0, result}, {16'h0, v.res});
    chk({tag, " carry"},   {31'h0, carry_out},    {31'h0, v.c});
    chk({tag, " zero"},    {31'h0, zero_out},     {31'h0, v.z});
    chk({tag, " ovf"},     {31'h0, overflow_out}, {31'h0, v.v});
    chk({tag, " busy@done"}, {31'h0, busy}, 32'h0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   seen_done;

  initial begin
    tbl[0] = '{16'h0FFF, 16'h0001, 0, 0, 0, 2'd0, 16'h1000, 0, 0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 0, 0, 0, 2'd0, 16'h0000, 1, 1, 0};
    tbl[2] = '{16'h8000, 16'h0001, 1, 0, 1, 2'd0, 16'h7FFF, 1, 0, 1};
    tbl[3] = '{16'h7FFF, 16'h0001, 0, 0, 0, 2'd0, 16'h8000, 0, 0, 1};
    tbl[4] = '{16'hF0F0, 16'h3C3C, 0, 0, 0, 2'd1, 16'h3030, 0, 0, 0};
    tbl[5] = '{16'hAAAA, 16'hAAAA, 1, 0, 0, 2'd3, 16'h0000, 0, 1, 0};
    tbl[6] = '{16'h0000, 16'hFFFF, 0, 0, 1, 2'd2, 16'h0000, 0, 1, 0};
    tbl[7] = '{16'h1234, 16'h5678, 0, 1, 0, 2'd0, 16'h1234, 0, 0, 0};

    // Reset state
    #2;
    chk("rst busy", {31'h0, busy}, 0);
    chk("rst done", {31'h0, done}, 0);
    chk("rst result", {16'h0, result}, 0);
    chk("rst flags", {29'h0, carry_out, zero_out, overflow_out}, 0);
    chk("rst alu_a", {28'h0, alu_a}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: second start issued in the done cycle.
    run_op('{16'h1234, 16'hFFFF, 0, 1, 0, 2'd0, 16'h1234, 0, 0, 0}, "b2b first");
    chk("b2b done before restart", {31'h0, done}, 1);
    run_op('{16'h0000, 16'hFFFF, 0, 1, 0, 2'd0, 16'h0000, 0, 1, 0}, "b2b second");

    // start and new operands mid-run are ignored and not queued.
    @(negedge clk);
    opa = 16'h1111; opb = 16'h2222; cin = 0; b_zero_in = 0; b_inv_in = 0; op_in = 2'd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    opa = 16'hFFFF; opb = 16'hFFFF; cin = 1; b_inv_in = 1; op_in = 2'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10 && seen_done == 0; i++) begin
      if (done) seen_done = 1; else @(negedge clk);
    end
    chk("ignore done seen", seen_done, 1);
    chk("ignore result", {16'h0, result}, 32'h3333);
    @(negedge clk);
    chk("ignore not queued", {31'h0, busy}, 0);

    // Asynchronous reset mid-run.
    run_op('{16'h1234, 16'h1111, 0, 0, 0, 2'd0, 16'h2345, 0, 0, 0}, "pre-rst");
    @(negedge clk);
    opa = 16'h4321; opb = 16'h1111; start = 1'b1; cin = 0; b_inv_in = 0; b_zero_in = 0; op_in = 0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'h0, busy}, 0);
    chk("midrst result", {16'h0, result}, 0);
    chk("midrst alu_b", {28'h0, alu_b}, 0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("midrst no done", seen_done, 0);
    run_op('{16'h4321, 16'h1111, 0, 0, 0, 2'd0, 16'h5432, 0, 0, 0}, "post-rst");

    // Randomized operations against the word-level model.
    for (int n = 0; n < 40; n++) begin
      rv = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(rv, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
